debug_cmd_controller: RTL and testbench
=======================================

Name: debug_cmd_controller

Overview:
- Command sequencer for the debug port.
- Accepts a byte stream from the debug UART, parses opcode/argument frames and sequences debug memory reads/writes, breakpoint loads and CPU halt/run/step requests.
- Returns read data and ACK/NAK bytes on a byte transmit channel.
- Sits between the debug UART and the debug memory/breakpoint datapath; it is the only master of those strobes.

Parameters:
ADDR_W, 16, debug address width (wraps modulo 2^ADDR_W)
DATA_W, 16, debug data word width (fixed 2 bytes on the wire)
TIMEOUT, 255, max cycles waiting for DBG_ACK or CPU_HALTED before NAK

Ports:
CLK  in  1  clock, all state on posedge
RESET  in  1  asynchronous, active-high reset
RX_DATA  in  8  received byte
RX_VALID  in  1  RX_DATA valid
RX_READY  out  1  controller accepts byte; transfer when RX_VALID&RX_READY at posedge
TX_DATA  out  8  byte to send
TX_VALID  out  1  TX_DATA valid, held until TX_READY
TX_READY  in  1  transmitter accepts byte
CPU_HALTED  in  1  CPU is stopped
HALT_REQ  out  1  level, held until CPU_HALTED or timeout
RUN_REQ  out  1  one-cycle pulse
STEP_REQ  out  1  one-cycle pulse
DBG_ADDR  out  ADDR_W  current debug address register
DBG_WDATA  out  DATA_W  write data
DBG_RDATA  in  DATA_W  read data, valid in DBG_ACK cycle
DBG_RD_REQ  out  1  read request, held until DBG_ACK
DBG_WR_REQ  out  1  write request, held until DBG_ACK
DBG_ACK  in  1  memory access complete
BKP_ADDR  out  ADDR_W  breakpoint address
BKP_WR  out  1  one-cycle pulse loading BKP_ADDR
BUSY  out  1  high in every state except IDLE

Behaviour:
- Reset: all outputs 0, DBG_ADDR=0, BKP_ADDR=0, DBG_WDATA=0, state IDLE. RESET mid-frame abandons the frame; no partial byte is sent.
- Frame: opcode byte, then 0-2 argument bytes, big-endian (hi first).
- Opcodes:
  - 0x01 SET_ADDR(hi,lo): load DBG_ADDR; reply 0x06.
  - 0x02 READ(n): n words, n=0 means 256. Per word: RD_REQ, wait ACK, send hi byte then lo byte, DBG_ADDR+1. No trailing ACK byte.
  - 0x03 WRITE(hi,lo): load DBG_WDATA; WR_REQ until ACK; DBG_ADDR+1; reply 0x06.
  - 0x04 SET_BKP(hi,lo): load BKP_ADDR, pulse BKP_WR; reply 0x06.
  - 0x05 HALT: HALT_REQ until CPU_HALTED; reply 0x06.
  - 0x06 RUN: pulse RUN_REQ; reply 0x06.
  - 0x07 STEP: pulse STEP_REQ; reply 0x06.
  - Any other opcode: reply 0x15 (NAK) with no argument bytes consumed.
- Guards:
  - READ, WRITE and STEP with CPU_HALTED=0 at EXEC: reply 0x15, no strobe.
  - HALT when already halted: immediate 0x06.
- States: IDLE, ARG_HI, ARG_LO, EXEC, MEM_WAIT, TX_HI, TX_LO, TX_RESP, HALT_WAIT.
  - IDLE → ARG_HI (opcodes 01/03/04), ARG_LO (02), or EXEC (05-07, unknown).
  - ARG_HI → ARG_LO → EXEC.
  - EXEC → MEM_WAIT, HALT_WAIT or TX_RESP.
  - MEM_WAIT → TX_HI (read) or TX_RESP (write).
  - TX_HI → TX_LO → MEM_WAIT (next word) or IDLE (last word).
  - TX_RESP → IDLE once the byte is accepted.
- RX_READY=1 only in IDLE, ARG_HI and ARG_LO.
- Latency: request strobe asserted the cycle after the last frame byte is accepted; pulses last exactly 1 cycle.
- DBG_RD_REQ/DBG_WR_REQ drop the cycle after DBG_ACK. DBG_RDATA is captured on the ACK cycle. DBG_ACK outside MEM_WAIT is ignored.
- Timeout: counter cleared on entry to MEM_WAIT/HALT_WAIT. At TIMEOUT cycles: drop the request, reply 0x15, IDLE. An aborted READ leaves DBG_ADDR at the failed word.
- DBG_ADDR increments wrap from 2^ADDR_W-1 to 0.
- TX_DATA/TX_VALID are stable while TX_VALID=1 and TX_READY=0.

Decomposition:
- Shared package holds opcode constants (CMD_SET_ADDR..CMD_STEP), reply bytes (RSP_ACK=0x06, RSP_NAK=0x15) and the state encoding.
- One sub-module, debug_timeout_counter: clear/enable input, terminal-count output.

Test Plan:
- Halted CPU; send 01 12 34, then 03 AB CD → WR_REQ with ADDR=0x1234, WDATA=0xABCD; ACK after 3 cycles → TX 06 06; DBG_ADDR=0x1235.
- Halted CPU; SET_ADDR FFFF, then 02 02; memory returns 0x1111, 0x2222 → TX 11 11 22 22; addresses FFFF then 0000; final DBG_ADDR=0x0001.
- CPU running; send 02 01 → TX 15, no RD_REQ. Send 05 with CPU_HALTED rising 10 cycles later → HALT_REQ high 10 cycles, TX 06.
- 04 00 80 → BKP_WR one cycle with BKP_ADDR=0x0080, TX 06. Opcode 0x7F → TX 15; next byte is parsed as an opcode.
- Halted CPU, READ with DBG_ACK never asserted → RD_REQ drops after 255 cycles, TX 15, BUSY=0.
- RESET asserted in ARG_LO and in MEM_WAIT with TX_READY=0 → all outputs 0 immediately; next frame parses normally.

Source files
------------

// File: rtl/debug_cmd_controller_pkg.sv
// debug_cmd_controller_pkg: shared opcodes, reply bytes, FSM state encoding and
// opcode classification helpers for the debug command controller.
package debug_cmd_controller_pkg;

    localparam logic [7:0] CMD_SET_ADDR = 8'h01;
    localparam logic [7:0] CMD_READ     = 8'h02;
    localparam logic [7:0] CMD_WRITE    = 8'h03;
    localparam logic [7:0] CMD_SET_BKP  = 8'h04;
    localparam logic [7:0] CMD_HALT     = 8'h05;
    localparam logic [7:0] CMD_RUN      = 8'h06;
    localparam logic [7:0] CMD_STEP     = 8'h07;

    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ARG_HI,
        S_ARG_LO,
        S_EXEC,
        S_MEM_WAIT,
        S_TX_HI,
        S_TX_LO,
        S_TX_RESP,
        S_HALT_WAIT
    } state_t;

    // Opcodes that carry a 16-bit big-endian argument.
    function automatic logic has_two_args(input logic [7:0] op);
        return op == CMD_SET_ADDR || op == CMD_WRITE || op == CMD_SET_BKP;
    endfunction

    // Opcodes that are refused unless the CPU is already stopped.
    function automatic logic needs_halt(input logic [7:0] op);
        return op == CMD_READ || op == CMD_WRITE || op == CMD_STEP;
    endfunction

    function automatic logic is_known(input logic [7:0] op);
        return op >= CMD_SET_ADDR && op <= CMD_STEP;
    endfunction

endpackage

// File: rtl/debug_timeout_counter.sv
// debug_timeout_counter: cycle counter for bounded waits.
//   CLK, RESET : clock, asynchronous active-high reset
//   clear      : synchronously returns the count to zero (has priority)
//   enable     : counts one per cycle while high
//   done       : high on the TIMEOUT-th enabled cycle since the last clear
module debug_timeout_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clear,
    input  logic enable,
    output logic done
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable)
            cnt <= cnt + CW'(1);
    end

    assign done = enable && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/debug_cmd_controller.sv
// debug_cmd_controller: parses opcode/argument frames from the debug UART and
// sequences debug memory accesses, breakpoint loads and CPU halt/run/step.
//   CLK, RESET              : clock, asynchronous active-high reset
//   RX_DATA/VALID/READY     : incoming command bytes
//   TX_DATA/VALID/READY     : outgoing read data and ACK/NAK bytes
//   CPU_HALTED              : CPU stopped status
//   HALT_REQ/RUN_REQ/STEP_REQ : CPU control (level / pulse / pulse)
//   DBG_ADDR/WDATA/RDATA    : debug memory address, write and read data
//   DBG_RD_REQ/WR_REQ/ACK   : debug memory handshake
//   BKP_ADDR/BKP_WR         : breakpoint address and load pulse
//   BUSY                    : a frame is being processed
module debug_cmd_controller
    import debug_cmd_controller_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [7:0]        RX_DATA,
    input  logic              RX_VALID,
    output logic              RX_READY,
    output logic [7:0]        TX_DATA,
    output logic              TX_VALID,
    input  logic              TX_READY,
    input  logic              CPU_HALTED,
    output logic              HALT_REQ,
    output logic              RUN_REQ,
    output logic              STEP_REQ,
    output logic [ADDR_W-1:0] DBG_ADDR,
    output logic [DATA_W-1:0] DBG_WDATA,
    input  logic [DATA_W-1:0] DBG_RDATA,
    output logic              DBG_RD_REQ,
    output logic              DBG_WR_REQ,
    input  logic              DBG_ACK,
    output logic [ADDR_W-1:0] BKP_ADDR,
    output logic              BKP_WR,
    output logic              BUSY
);

    state_t      state, state_nxt;
    logic [7:0]  opcode, arg_hi, resp;
    logic [8:0]  words;
    logic [15:0] rdata;
    logic        nak, tmo, waiting, rx_fire, tx_fire, exec, to_resp;

    assign exec     = state == S_EXEC;
    assign waiting  = state == S_MEM_WAIT || state == S_HALT_WAIT;
    // Gated by RESET so every output reads zero while reset is held.
    assign RX_READY = !RESET && (state == S_IDLE || state == S_ARG_HI || state == S_ARG_LO);
    assign TX_VALID = state == S_TX_HI || state == S_TX_LO || state == S_TX_RESP;
    assign TX_DATA  = state == S_TX_HI   ? rdata[15:8] :
                      state == S_TX_LO   ? rdata[7:0]  :
                      state == S_TX_RESP ? resp        : 8'h00;
    assign rx_fire  = RX_VALID && RX_READY;
    assign tx_fire  = TX_VALID && TX_READY;
    assign BUSY     = state != S_IDLE;
    assign to_resp  = state_nxt == S_TX_RESP && state != S_TX_RESP;

    // Requests start in EXEC so they appear the cycle after the last frame
    // byte; the guard on CPU_HALTED suppresses them when the command is refused.
    assign DBG_RD_REQ = opcode == CMD_READ  && ((exec && CPU_HALTED) || state == S_MEM_WAIT);
    assign DBG_WR_REQ = opcode == CMD_WRITE && ((exec && CPU_HALTED) || state == S_MEM_WAIT);
    assign HALT_REQ   = (exec && opcode == CMD_HALT && !CPU_HALTED) || state == S_HALT_WAIT;
    assign RUN_REQ    = exec && opcode == CMD_RUN;
    assign STEP_REQ   = exec && opcode == CMD_STEP && CPU_HALTED;
    assign BKP_WR     = exec && opcode == CMD_SET_BKP;

    debug_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .CLK    (CLK),
        .RESET  (RESET),
        .clear  (!waiting),
        .enable (waiting),
        .done   (tmo)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        nak       = 1'b0;
        unique case (state)
            S_IDLE:
                if (rx_fire)
                    state_nxt = has_two_args(RX_DATA) ? S_ARG_HI :
                                RX_DATA == CMD_READ   ? S_ARG_LO : S_EXEC;
            S_ARG_HI:
                if (rx_fire) state_nxt = S_ARG_LO;
            S_ARG_LO:
                if (rx_fire) state_nxt = S_EXEC;
            S_EXEC:
                if ((opcode == CMD_READ || opcode == CMD_WRITE) && CPU_HALTED)
                    state_nxt = S_MEM_WAIT;
                else if (opcode == CMD_HALT && !CPU_HALTED)
                    state_nxt = S_HALT_WAIT;
                else begin
                    state_nxt = S_TX_RESP;
                    nak       = !is_known(opcode) || (needs_halt(opcode) && !CPU_HALTED);
                end
            S_MEM_WAIT:
                if (DBG_ACK)
                    state_nxt = opcode == CMD_READ ? S_TX_HI : S_TX_RESP;
                else if (tmo) begin
                    state_nxt = S_TX_RESP;
                    nak       = 1'b1;
                end
            S_TX_HI:
                if (tx_fire) state_nxt = S_TX_LO;
            S_TX_LO:
                if (tx_fire) state_nxt = words == 9'd1 ? S_IDLE : S_MEM_WAIT;
            S_TX_RESP:
                if (tx_fire) state_nxt = S_IDLE;
            S_HALT_WAIT:
                if (CPU_HALTED)
                    state_nxt = S_TX_RESP;
                else if (tmo) begin
                    state_nxt = S_TX_RESP;
                    nak       = 1'b1;
                end
            default:
                state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            opcode    <= '0;
            arg_hi    <= '0;
            words     <= '0;
            rdata     <= '0;
            resp      <= '0;
            DBG_ADDR  <= '0;
            DBG_WDATA <= '0;
            BKP_ADDR  <= '0;
        end else begin
            if (state == S_IDLE && rx_fire)
                opcode <= RX_DATA;
            if (state == S_ARG_HI && rx_fire)
                arg_hi <= RX_DATA;
            // Argument registers are loaded on the last frame byte so they are
            // already valid alongside the strobe issued in EXEC.
            if (state == S_ARG_LO && rx_fire) begin
                if (opcode == CMD_SET_ADDR)
                    DBG_ADDR <= ADDR_W'({arg_hi, RX_DATA});
                if (opcode == CMD_WRITE)
                    DBG_WDATA <= DATA_W'({arg_hi, RX_DATA});
                if (opcode == CMD_SET_BKP)
                    BKP_ADDR <= ADDR_W'({arg_hi, RX_DATA});
                if (opcode == CMD_READ)
                    words <= {RX_DATA == 8'h00, RX_DATA};
            end
            if (state == S_MEM_WAIT && DBG_ACK) begin
                rdata <= 16'(DBG_RDATA);
                if (opcode == CMD_WRITE)
                    DBG_ADDR <= DBG_ADDR + ADDR_W'(1);
            end
            // A read advances only once both bytes of the word have gone out,
            // so a timed-out read leaves the address on the failing word.
            if (state == S_TX_LO && tx_fire) begin
                DBG_ADDR <= DBG_ADDR + ADDR_W'(1);
                words    <= words - 9'd1;
            end
            if (to_resp)
                resp <= nak ? RSP_NAK : RSP_ACK;
        end
    end

endmodule

// File: tb/tb_debug_cmd_controller.sv
// tb_debug_cmd_controller: directed self-checking bench for debug_cmd_controller.
module tb_debug_cmd_controller;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [7:0]  RX_DATA;
    logic        RX_VALID;
    logic        RX_READY;
    logic [7:0]  TX_DATA;
    logic        TX_VALID;
    logic        TX_READY;
    logic        CPU_HALTED;
    logic        HALT_REQ, RUN_REQ, STEP_REQ;
    logic [15:0] DBG_ADDR, DBG_WDATA, DBG_RDATA, BKP_ADDR;
    logic        DBG_RD_REQ, DBG_WR_REQ, DBG_ACK, BKP_WR, BUSY;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] txq[$];

    always #5 CLK = ~CLK;

    debug_cmd_controller dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .RX_DATA    (RX_DATA),
        .RX_VALID   (RX_VALID),
        .RX_READY   (RX_READY),
        .TX_DATA    (TX_DATA),
        .TX_VALID   (TX_VALID),
        .TX_READY   (TX_READY),
        .CPU_HALTED (CPU_HALTED),
        .HALT_REQ   (HALT_REQ),
        .RUN_REQ    (RUN_REQ),
        .STEP_REQ   (STEP_REQ),
        .DBG_ADDR   (DBG_ADDR),
        .DBG_WDATA  (DBG_WDATA),
        .DBG_RDATA  (DBG_RDATA),
        .DBG_RD_REQ (DBG_RD_REQ),
        .DBG_WR_REQ (DBG_WR_REQ),
        .DBG_ACK    (DBG_ACK),
        .BKP_ADDR   (BKP_ADDR),
        .BKP_WR     (BKP_WR),
        .BUSY       (BUSY)
    );

    always @(posedge CLK)
        if (!RESET && TX_VALID && TX_READY)
            txq.push_back(TX_DATA);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int t = 0;
        RX_DATA  = b;
        RX_VALID = 1'b1;
        #0;
        while (!RX_READY && t < 100) begin
            tick();
            t++;
        end
        if (t == 100)
            chk("rx_ready_wait", {31'd0, RX_READY}, 32'd1);
        tick();
        RX_VALID = 1'b0;
        RX_DATA  = 8'h00;
    endtask

    task automatic expect_tx(input string tag, input logic [7:0] b);
        int t = 0;
        logic [7:0] got = 'x;
        while (txq.size() == 0 && t < 600) begin
            tick();
            t++;
        end
        if (txq.size() != 0)
            got = txq.pop_front();
        chk(tag, {24'd0, got}, {24'd0, b});
    endtask

    task automatic mem_ack(input logic [15:0] d);
        DBG_RDATA = d;
        DBG_ACK   = 1'b1;
        tick();
        DBG_ACK   = 1'b0;
    endtask

    initial begin
        int hcnt;
        int rcnt;
        RESET = 1'b1; RX_DATA = 8'h00; RX_VALID = 1'b0; TX_READY = 1'b1;
        CPU_HALTED = 1'b0; DBG_RDATA = 16'h0000; DBG_ACK = 1'b0;
        tick(); tick();
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_rx_ready", {31'd0, RX_READY}, 32'd0);
        chk("rst_tx_valid", {31'd0, TX_VALID}, 32'd0);
        chk("rst_addr", {16'd0, DBG_ADDR}, 32'h0);
        chk("rst_bkp", {16'd0, BKP_ADDR}, 32'h0);
        RESET = 1'b0;
        tick();
        chk("idle_rx_ready", {31'd0, RX_READY}, 32'd1);

        // Write with a three-cycle acknowledge.
        CPU_HALTED = 1'b1;
        send(8'h01); send(8'h12); send(8'h34);
        expect_tx("set_addr_ack", 8'h06);
        chk("set_addr", {16'd0, DBG_ADDR}, 32'h1234);
        send(8'h03); send(8'hAB); send(8'hCD);
        chk("wr_req_first", {31'd0, DBG_WR_REQ}, 32'd1);
        chk("wr_addr", {16'd0, DBG_ADDR}, 32'h1234);
        chk("wr_data", {16'd0, DBG_WDATA}, 32'hABCD);
        chk("wr_busy", {31'd0, BUSY}, 32'd1);
        tick(); tick(); tick();
        DBG_ACK = 1'b1;
        #0;
        chk("wr_req_held", {31'd0, DBG_WR_REQ}, 32'd1);
        tick();
        DBG_ACK = 1'b0;
        chk("wr_req_drop", {31'd0, DBG_WR_REQ}, 32'd0);
        expect_tx("write_ack", 8'h06);
        chk("wr_addr_inc", {16'd0, DBG_ADDR}, 32'h1235);

        // Two-word read across the address wrap.
        send(8'h01); send(8'hFF); send(8'hFF);
        expect_tx("set_ffff_ack", 8'h06);
        send(8'h02); send(8'h02);
        chk("rd_req_w0", {31'd0, DBG_RD_REQ}, 32'd1);
        chk("rd_addr_w0", {16'd0, DBG_ADDR}, 32'hFFFF);
        tick();
        mem_ack(16'h1111);
        chk("rd_req_drop", {31'd0, DBG_RD_REQ}, 32'd0);
        rcnt = 0;
        while (!DBG_RD_REQ && rcnt < 20) begin
            tick();
            rcnt++;
        end
        chk("rd_req_w1", {31'd0, DBG_RD_REQ}, 32'd1);
        chk("rd_addr_w1", {16'd0, DBG_ADDR}, 32'h0000);
        mem_ack(16'h2222);
        expect_tx("rd_b0", 8'h11);
        expect_tx("rd_b1", 8'h11);
        expect_tx("rd_b2", 8'h22);
        expect_tx("rd_b3", 8'h22);
        chk("rd_addr_final", {16'd0, DBG_ADDR}, 32'h0001);
        chk("rd_busy_done", {31'd0, BUSY}, 32'd0);

        // Read refused while running, then halt taking ten cycles.
        CPU_HALTED = 1'b0;
        send(8'h02); send(8'h01);
        chk("rd_running_noreq", {31'd0, DBG_RD_REQ}, 32'd0);
        expect_tx("rd_running_nak", 8'h15);
        send(8'h05);
        hcnt = 0;
        for (int i = 0; i < 40 && !(hcnt > 0 && !HALT_REQ); i++) begin
            if (HALT_REQ) hcnt++;
            if (hcnt == 10) CPU_HALTED = 1'b1;
            tick();
        end
        chk("halt_req_cycles", hcnt, 32'd10);
        expect_tx("halt_ack", 8'h06);
        send(8'h05);
        chk("halt_already_noreq", {31'd0, HALT_REQ}, 32'd0);
        expect_tx("halt_already_ack", 8'h06);

        // Breakpoint load, unknown opcode, run and step.
        send(8'h04); send(8'h00); send(8'h80);
        chk("bkp_wr_pulse", {31'd0, BKP_WR}, 32'd1);
        chk("bkp_addr", {16'd0, BKP_ADDR}, 32'h0080);
        tick();
        chk("bkp_wr_end", {31'd0, BKP_WR}, 32'd0);
        expect_tx("bkp_ack", 8'h06);
        send(8'h7F);
        expect_tx("unknown_nak", 8'h15);
        send(8'h06);
        chk("run_pulse", {31'd0, RUN_REQ}, 32'd1);
        tick();
        chk("run_end", {31'd0, RUN_REQ}, 32'd0);
        expect_tx("run_ack", 8'h06);
        send(8'h07);
        chk("step_pulse", {31'd0, STEP_REQ}, 32'd1);
        tick();
        chk("step_end", {31'd0, STEP_REQ}, 32'd0);
        expect_tx("step_ack", 8'h06);

        // Read whose acknowledge never comes.
        send(8'h02); send(8'h01);
        rcnt = 0;
        while (DBG_RD_REQ && rcnt < 400) begin
            rcnt++;
            tick();
        end
        chk("tmo_req_len", {31'd0, rcnt >= 255 && rcnt <= 256}, 32'd1);
        expect_tx("tmo_nak", 8'h15);
        chk("tmo_busy", {31'd0, BUSY}, 32'd0);
        chk("tmo_addr", {16'd0, DBG_ADDR}, 32'h0001);

        // Reset in ARG_LO.
        send(8'h01); send(8'hAB);
        chk("argl_busy", {31'd0, BUSY}, 32'd1);
        RESET = 1'b1;
        #1;
        chk("argl_rst_busy", {31'd0, BUSY}, 32'd0);
        chk("argl_rst_addr", {16'd0, DBG_ADDR}, 32'h0);
        chk("argl_rst_rx", {31'd0, RX_READY}, 32'd0);
        tick();
        RESET = 1'b0;

        // Reset in MEM_WAIT with the transmitter stalled.
        TX_READY = 1'b0;
        send(8'h02); send(8'h01);
        tick();
        chk("mw_rd_req", {31'd0, DBG_RD_REQ}, 32'd1);
        RESET = 1'b1;
        #1;
        chk("mw_rst_rd_req", {31'd0, DBG_RD_REQ}, 32'd0);
        chk("mw_rst_busy", {31'd0, BUSY}, 32'd0);
        chk("mw_rst_tx", {23'd0, TX_VALID, TX_DATA}, 32'd0);
        tick();
        RESET = 1'b0;
        TX_READY = 1'b1;
        tick();
        chk("no_partial_tx", txq.size(), 32'd0);
        send(8'h01); send(8'h56); send(8'h78);
        expect_tx("post_rst_ack", 8'h06);
        chk("post_rst_addr", {16'd0, DBG_ADDR}, 32'h5678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
